// File: rtl/button_debouncer_multi.sv
// Multi-channel button conditioner: per-channel synchroniser, tick-gated stability
// filter, one-cycle press/release pulses and optional long-press detection.
module button_debouncer_multi #(
    parameter int NUM_CH       = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int STABLE_TICKS = 8,
    parameter int SAMPLE_DIV   = 1,
    parameter int HOLD_TICKS   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] btn_in,
    output logic [NUM_CH-1:0] btn_state,
    output logic [NUM_CH-1:0] btn_press,
    output logic [NUM_CH-1:0] btn_release,
    output logic [NUM_CH-1:0] btn_long,
    output logic [NUM_CH-1:0] btn_held
);

    localparam int STAB_W = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
    localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int HOLD_W = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_TICKS - 1);

    logic tick;

    generate
        if (SAMPLE_DIV == 1) begin : g_no_div
            assign tick = 1'b1;
        end else begin : g_div
            localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
            logic [DIV_W-1:0] div_reg;

            assign tick = (div_reg == DIV_LAST);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    div_reg <= '0;
                end else if (tick) begin
                    div_reg <= '0;
                end else begin
                    div_reg <= div_reg + 1'b1;
                end
            end
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_reg;
            logic [STAB_W-1:0]      stab_reg;
            logic                   state_reg;
            logic                   press_reg;
            logic                   release_reg;
            logic                   sync_out;
            logic                   accept;

            assign sync_out = sync_reg[SYNC_STAGES-1];
            // New level is taken on the tick that completes the run of differing samples.
            assign accept   = tick && (sync_out != state_reg) && (stab_reg == STAB_LAST);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync_reg    <= '0;
                    stab_reg    <= '0;
                    state_reg   <= 1'b0;
                    press_reg   <= 1'b0;
                    release_reg <= 1'b0;
                end else begin
                    sync_reg    <= {sync_reg[SYNC_STAGES-2:0], btn_in[gi]};
                    press_reg   <= accept && sync_out;
                    release_reg <= accept && !sync_out;
                    if (tick) begin
                        if (sync_out == state_reg) begin
                            stab_reg <= '0;
                        end else if (stab_reg == STAB_LAST) begin
                            state_reg <= sync_out;
                            stab_reg  <= '0;
                        end else begin
                            stab_reg <= stab_reg + 1'b1;
                        end
                    end
                end
            end

            assign btn_state[gi]   = state_reg;
            assign btn_press[gi]   = press_reg;
            assign btn_release[gi] = release_reg;

            if (HOLD_TICKS > 0) begin : g_hold
                localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_TICKS);
                localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);
                logic [HOLD_W-1:0] hold_reg;
                logic              long_reg;
                logic              held_reg;

                // Counting uses the pre-update level, so the rising tick itself is not counted.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        hold_reg <= '0;
                        long_reg <= 1'b0;
                        held_reg <= 1'b0;
                    end else begin
                        long_reg <= 1'b0;
                        if (accept && !sync_out) begin
                            hold_reg <= '0;
                            held_reg <= 1'b0;
                        end else if (tick && state_reg && (hold_reg != HOLD_MAX)) begin
                            hold_reg <= hold_reg + 1'b1;
                            if (hold_reg == HOLD_LAST) begin
                                long_reg <= 1'b1;
                                held_reg <= 1'b1;
                            end
                        end
                    end
                end

                assign btn_long[gi] = long_reg;
                assign btn_held[gi] = held_reg;
            end else begin : g_no_hold
                assign btn_long[gi] = 1'b0;
                assign btn_held[gi] = 1'b0;
            end
        end
    endgenerate

endmodule

// File: tb/tb_button_debouncer_multi.sv
// Bench for button_debouncer_multi: default build plus a slow-sampled build without
// long-press; expected pulses are queued by the stimulus and matched by a monitor.
module tb_button_debouncer_multi;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn1;
    logic [3:0] state1, press1, rel1, long1, held1;
    logic [1:0] btn2;
    logic [1:0] state2, press2, rel2, long2, held2;

    always #5 clk = ~clk;

    button_debouncer_multi dut1 (
        .clk(clk), .rst(rst), .btn_in(btn1),
        .btn_state(state1), .btn_press(press1), .btn_release(rel1),
        .btn_long(long1), .btn_held(held1)
    );

    button_debouncer_multi #(
        .NUM_CH(2), .SYNC_STAGES(2), .STABLE_TICKS(3), .SAMPLE_DIV(4), .HOLD_TICKS(0)
    ) dut2 (
        .clk(clk), .rst(rst), .btn_in(btn2),
        .btn_state(state2), .btn_press(press2), .btn_release(rel2),
        .btn_long(long2), .btn_held(held2)
    );

    typedef struct {
        int         cyc;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] lng;
        logic [3:0] state;
        logic [3:0] held;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    int   cyc     = 0;
    int   rcyc    = 0;
    int   errors  = 0;
    int   checks  = 0;
    logic sticky2 = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push1(input int c, input logic [3:0] p, r, l, s, h);
        q1.push_back('{c, p, r, l, s, h});
    endtask

    task automatic push2(input int c, input logic [3:0] p, r, l, s, h);
        q2.push_back('{c, p, r, l, s, h});
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic compare(input string nm, input exp_t e,
                           input logic [3:0] p, r, l, s, h);
        checks++;
        if (e.cyc != cyc || e.press !== p || e.rel !== r || e.lng !== l ||
            e.state !== s || e.held !== h) begin
            errors++;
            $display("FAIL %s: got cyc=%0d press=%b rel=%b long=%b state=%b held=%b, required cyc=%0d press=%b rel=%b long=%b state=%b held=%b",
                     nm, cyc, p, r, l, s, h, e.cyc, e.press, e.rel, e.lng, e.state, e.held);
        end else begin
            $display("ok   %s: cyc=%0d press=%b rel=%b long=%b state=%b held=%b",
                     nm, cyc, p, r, l, s, h);
        end
    endtask

    // Monitor: any pulse pops the next expectation; an overdue expectation is a miss.
    always @(negedge clk) begin
        if (!rst) begin
            if (q1.size() > 0 && q1[0].cyc < cyc) begin
                checks++; errors++;
                $display("FAIL dut1_missed: no pulse at cyc=%0d, required one at cyc=%0d", cyc, q1[0].cyc);
                q1.delete(0);
            end
            if (|{press1, rel1, long1}) begin
                if (q1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL dut1_unexpected: cyc=%0d press=%b rel=%b long=%b, required no pulse",
                             cyc, press1, rel1, long1);
                end else begin
                    compare("dut1_event", q1[0], press1, rel1, long1, state1, held1);
                    q1.delete(0);
                end
            end
            if (q2.size() > 0 && q2[0].cyc < cyc) begin
                checks++; errors++;
                $display("FAIL dut2_missed: no pulse at cyc=%0d, required one at cyc=%0d", cyc, q2[0].cyc);
                q2.delete(0);
            end
            if (|{press2, rel2, long2}) begin
                if (q2.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL dut2_unexpected: cyc=%0d press=%b rel=%b long=%b, required no pulse",
                             cyc, press2, rel2, long2);
                end else begin
                    compare("dut2_event", q2[0], {2'b00, press2}, {2'b00, rel2},
                            {2'b00, long2}, {2'b00, state2}, {2'b00, held2});
                    q2.delete(0);
                end
            end
            sticky2 = sticky2 | (|long2) | (|held2);
        end
    end

    task automatic check_all_zero(input string nm);
        checks++;
        if ({state1, press1, rel1, long1, held1, state2, press2, rel2, long2, held2} !== '0) begin
            errors++;
            $display("FAIL %s: dut1 state=%b press=%b rel=%b long=%b held=%b dut2 state=%b press=%b rel=%b long=%b held=%b, required all 0",
                     nm, state1, press1, rel1, long1, held1, state2, press2, rel2, long2, held2);
        end else begin
            $display("ok   %s: all outputs 0 at cyc=%0d", nm, cyc);
        end
    endtask

    task automatic align_tick_phase();
        while (((cyc - rcyc) % 4) != 2) wait_cyc(1);
    endtask

    initial begin
        int last;
        int t;
        rst  = 1'b1;
        btn1 = '0;
        btn2 = '0;
        wait_cyc(3);
        check_all_zero("reset_state");
        rst  = 1'b0;
        rcyc = cyc;
        wait_cyc(2);

        // Clean step on channel 0, then long press while held.
        btn1[0] = 1'b1;
        push1(cyc + 10, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
        push1(cyc + 26, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001);
        wait_cyc(30);

        // Channel 1 bounces with 3-cycle runs, last edge leaves it at 1.
        last = cyc;
        for (int i = 0; i < 13; i++) begin
            btn1[1] = ~btn1[1];
            last = cyc;
            wait_cyc(3);
        end
        push1(last + 10, 4'b0010, 4'b0000, 4'b0000, 4'b0011, 4'b0001);
        push1(last + 26, 4'b0000, 4'b0000, 4'b0010, 4'b0011, 4'b0011);
        wait_cyc(30);

        btn1[1:0] = 2'b00;
        push1(cyc + 10, 4'b0000, 4'b0011, 4'b0000, 4'b0000, 4'b0000);
        wait_cyc(15);

        // Channel 2 long press and release.
        btn1[2] = 1'b1;
        t = cyc;
        push1(t + 10, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000);
        push1(t + 26, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0100);
        wait_cyc(40);
        btn1[2] = 1'b0;
        push1(cyc + 10, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
        wait_cyc(15);

        // All channels together, then partial release.
        btn1 = 4'b1111;
        t = cyc;
        push1(t + 10, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'b0000);
        push1(t + 26, 4'b0000, 4'b0000, 4'b1111, 4'b1111, 4'b1111);
        wait_cyc(35);
        btn1 = 4'b0001;
        push1(cyc + 10, 4'b0000, 4'b1110, 4'b0000, 4'b0001, 4'b0001);
        wait_cyc(15);

        // Reset mid-count while channel 0 is held and channel 1 is filtering.
        btn1[1] = 1'b1;
        wait_cyc(5);
        rst  = 1'b1;
        btn1 = '0;
        #1;
        check_all_zero("mid_reset");
        wait_cyc(3);
        rst  = 1'b0;
        rcyc = cyc;
        wait_cyc(30);

        // Slow-sampled build: step aligned so the first useful tick is 6 edges out.
        align_tick_phase();
        btn2[0] = 1'b1;
        t = cyc;
        push2(t + 14, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
        push2(t + 114, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        wait_cyc(100);
        btn2[0] = 1'b0;
        wait_cyc(20);

        // 10-cycle glitch covers only two differing ticks.
        align_tick_phase();
        btn2[1] = 1'b1;
        wait_cyc(10);
        btn2[1] = 1'b0;
        wait_cyc(30);

        checks++;
        if (q1.size() != 0) begin
            errors++;
            $display("FAIL dut1_pending: %0d expected events outstanding, required 0", q1.size());
        end
        checks++;
        if (q2.size() != 0) begin
            errors++;
            $display("FAIL dut2_pending: %0d expected events outstanding, required 0", q2.size());
        end
        checks++;
        if (sticky2 !== 1'b0) begin
            errors++;
            $display("FAIL dut2_no_long: long/held seen=%b, required 0", sticky2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
